joy_socd_filter: RTL
====================

JOY_SOCD_FILTER -- requirements
Module: joy_socd_filter

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2: number of independent joystick channels (1..4).
REQ-002 SHALL have parameter DB_TICKS, default 0: debounce length in ce_db ticks (0..255); 0 = no debounce.
REQ-003 SHALL have port clk  input  1: system clock; the only clock in the block.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port ce_db  input  1: debounce tick enable, single-cycle pulses.
REQ-006 SHALL have port dir_in  input  4*NUM_PLAYERS: raw directions; per player p, bits [4p+3:4p] = {U,D,L,R}, active-high, asynchronous.
REQ-007 SHALL have port mode  input  2: SOCD policy: 00 last-wins, 01 neutral, 10 first-wins, 11 passthrough.
REQ-008 SHALL have port four_way  input  1: 1 = restrict the output to a single axis.
REQ-009 SHALL have port rotate  input  1: 1 = 90-degree remap for horizontal screens.
REQ-010 SHALL have port dir_out  output  4*NUM_PLAYERS: filtered directions, same bit layout as dir_in, registered.

Function
REQ-011 Each dir_in bit SHALL pass through a 2-flop synchroniser.
REQ-012 When rotate=1, the synchronised vector SHALL be remapped per player before debounce: U'=L, D'=R, L'=D, R'=U. When rotate=0 the vector SHALL be unchanged.
REQ-013 Each bit SHALL have a stable register and a counter 8 bits wide:
- when synced == stable, the counter SHALL clear;
- otherwise the counter SHALL increment on each ce_db;
- stable SHALL take the synced value, and the counter SHALL clear, on the cycle the count would reach DB_TICKS.
REQ-014 With DB_TICKS=0, stable SHALL follow synced with a 1-cycle delay, and ce_db SHALL be ignored.
REQ-015 Per player and axis, a rising edge of a stable bit SHALL update last_h (L/R) or last_v (U/D). If both opposing directions rise in the same cycle, L and U SHALL win.
REQ-016 Axis resolution when both opposing stable bits are 1:
- last-wins: output the last_h / last_v direction;
- neutral: output 00;
- first-wins: hold the previous dir_out value for that axis (00 if it was 00);
- passthrough: output 11.
REQ-017 When the opposing bits are not both 1, each axis SHALL output its stable bits unchanged in every mode.
REQ-018 last_axis per player SHALL record the axis of the most recent stable rising edge. If both axes rise in the same cycle, last_axis SHALL be unchanged.
REQ-019 When four_way=1 and both resolved axes are non-zero, only the last_axis axis SHALL be output and the other axis forced to 00. Ignored when four_way=0.
REQ-020 dir_out SHALL be registered one cycle after stable. Total latency with DB_TICKS=0 SHALL be 4 clk cycles from dir_in change to dir_out.
REQ-021 Players SHALL be fully independent: no state sharing and no cross-player priority.
REQ-022 mode, four_way and rotate SHALL be treated as quasi-static. A change SHALL take effect on the next resolution cycle without corrupting history registers, and a rotate change SHALL propagate through debounce like any input change.
REQ-023 The counter SHALL saturate and never wrap: reaching DB_TICKS always commits and clears.

Reset
REQ-024 While reset_n=0, asynchronously:
- synchroniser flops, stable, counters and dir_out SHALL be 0;
- last_h and last_v SHALL be 00;
- last_axis SHALL be vertical.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count. After release, an input held at 1 SHALL reappear at dir_out with full latency and no glitch pulse.
REQ-026 After reset release, no edge SHALL be detected from the 0 reset state on inputs that are still 0.

Verification
REQ-027 Setup DB_TICKS=0, mode=00. Stimulus: P0 R=1, then L=1 held together 10 cycles later. Response: dir_out[1:0]=01 until L reaches output, then 10. Release L: 01 within 4 cycles.
REQ-028 Setup mode=10. Stimulus: hold R, then add L. Response: dir_out stays R=01. Stimulus: L and R rise in the same cycle from idle. Response: 00.
REQ-029 Setup mode=01, four_way=1. Stimulus: U then R (R later), then L added. Response:
- U only gives 1000;
- U+R gives 0001;
- adding L makes the horizontal axis neutral, so the output reverts to vertical 1000.
REQ-030 Setup DB_TICKS=3, ce_db every 4th cycle. Stimulus: a 2-tick pulse on D. Response: dir_out unchanged. Stimulus: D held 3 ticks. Response: dir_out D=1 after the 3rd tick plus 1 cycle.
REQ-031 Setup rotate=1, NUM_PLAYERS=2. Stimulus: P1 raw L=1. Response: dir_out[7:4]=1000. P0 outputs remain 0.
REQ-032 Stimulus: reset_n pulsed low mid-debounce with the input held. Response: dir_out=0 immediately. After release, D reasserts after 2+1 sync/stable cycles plus DB_TICKS ticks, then 1 output cycle.

Source files
------------

// File: rtl/joy_socd_filter.sv
// Joystick SOCD filter: synchronise, optional rotate, debounce, then
// resolve opposing directions per axis with an optional 4-way restriction.
module joy_socd_filter #(
    parameter int NUM_PLAYERS = 2,
    parameter int DB_TICKS    = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce_db,
    input  logic [4*NUM_PLAYERS-1:0] dir_in,
    input  logic [1:0]               mode,
    input  logic                     four_way,
    input  logic                     rotate,
    output logic [4*NUM_PLAYERS-1:0] dir_out
);

    localparam int NB = 4 * NUM_PLAYERS;
    localparam logic [8:0] DB_LIM = 9'(DB_TICKS);

    localparam logic AX_V = 1'b0;
    localparam logic AX_H = 1'b1;

    typedef enum logic [1:0] {
        M_LAST    = 2'b00,
        M_NEUTRAL = 2'b01,
        M_FIRST   = 2'b10,
        M_PASS    = 2'b11
    } socd_mode_e;

    logic [NB-1:0] meta_q;
    logic [NB-1:0] sync_q;
    logic [NB-1:0] rot_d;

    logic [NB-1:0]      stable_q;
    logic [NB-1:0]      stable_d;
    logic [NB-1:0][7:0] cnt_q;
    logic [NB-1:0][7:0] cnt_d;
    logic [NB-1:0]      rise;
    logic [8:0]         cnt_nx;
    logic               db_tick;

    logic [NUM_PLAYERS-1:0][1:0] last_h_q;
    logic [NUM_PLAYERS-1:0][1:0] last_h_d;
    logic [NUM_PLAYERS-1:0][1:0] last_v_q;
    logic [NUM_PLAYERS-1:0][1:0] last_v_d;
    logic [NUM_PLAYERS-1:0]      last_axis_q;
    logic [NUM_PLAYERS-1:0]      last_axis_d;

    logic [NUM_PLAYERS-1:0][1:0] res_h;
    logic [NUM_PLAYERS-1:0][1:0] res_v;
    logic [NB-1:0]               dir_out_q;
    logic [NB-1:0]               dir_out_d;

    function automatic logic [1:0] resolve_axis(
        input logic [1:0] s,
        input logic [1:0] last,
        input logic [1:0] prev,
        input logic [1:0] m
    );
        logic [1:0] r;
        r = s;
        if (s == 2'b11) begin
            unique case (socd_mode_e'(m))
                M_LAST:    r = last;
                M_NEUTRAL: r = 2'b00;
                M_FIRST:   r = prev;
                M_PASS:    r = 2'b11;
            endcase
        end
        return r;
    endfunction

    // Rotation sits after the synchroniser so a rotate flip debounces like input.
    always_comb begin
        rot_d = sync_q;
        if (rotate) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                rot_d[4*p+3] = sync_q[4*p+1];
                rot_d[4*p+2] = sync_q[4*p+0];
                rot_d[4*p+1] = sync_q[4*p+2];
                rot_d[4*p+0] = sync_q[4*p+3];
            end
        end
    end

    always_comb begin
        db_tick  = (DB_TICKS == 0) ? 1'b1 : ce_db;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        cnt_nx   = '0;
        for (int b = 0; b < NB; b++) begin
            cnt_nx = {1'b0, cnt_q[b]} + 9'd1;
            if (rot_d[b] == stable_q[b]) begin
                cnt_d[b] = '0;
            end else if (db_tick) begin
                if (cnt_nx >= DB_LIM) begin
                    stable_d[b] = rot_d[b];
                    cnt_d[b]    = '0;
                end else begin
                    cnt_d[b] = cnt_nx[7:0];
                end
            end
        end
    end

    assign rise = stable_d & ~stable_q;

    // History follows stable so resolution sees edge and level together.
    always_comb begin
        last_h_d    = last_h_q;
        last_v_d    = last_v_q;
        last_axis_d = last_axis_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (rise[4*p+1]) begin
                last_h_d[p] = 2'b10;
            end else if (rise[4*p+0]) begin
                last_h_d[p] = 2'b01;
            end
            if (rise[4*p+3]) begin
                last_v_d[p] = 2'b10;
            end else if (rise[4*p+2]) begin
                last_v_d[p] = 2'b01;
            end
            if ((rise[4*p+1] | rise[4*p+0]) && !(rise[4*p+3] | rise[4*p+2])) begin
                last_axis_d[p] = AX_H;
            end else if ((rise[4*p+3] | rise[4*p+2]) && !(rise[4*p+1] | rise[4*p+0])) begin
                last_axis_d[p] = AX_V;
            end
        end
    end

    always_comb begin
        res_h     = '0;
        res_v     = '0;
        dir_out_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            res_h[p] = resolve_axis(stable_q[4*p+1 -: 2], last_h_q[p],
                                    dir_out_q[4*p+1 -: 2], mode);
            res_v[p] = resolve_axis(stable_q[4*p+3 -: 2], last_v_q[p],
                                    dir_out_q[4*p+3 -: 2], mode);
            if (four_way && (res_h[p] != 2'b00) && (res_v[p] != 2'b00)) begin
                if (last_axis_q[p] == AX_H) begin
                    res_v[p] = 2'b00;
                end else begin
                    res_h[p] = 2'b00;
                end
            end
            dir_out_d[4*p +: 4] = {res_v[p], res_h[p]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q      <= '0;
            sync_q      <= '0;
            stable_q    <= '0;
            cnt_q       <= '0;
            last_h_q    <= '0;
            last_v_q    <= '0;
            last_axis_q <= {NUM_PLAYERS{AX_V}};
            dir_out_q   <= '0;
        end else begin
            meta_q      <= dir_in;
            sync_q      <= meta_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            last_h_q    <= last_h_d;
            last_v_q    <= last_v_d;
            last_axis_q <= last_axis_d;
            dir_out_q   <= dir_out_d;
        end
    end

    assign dir_out = dir_out_q;

endmodule
